// File: rtl/bram_dbg_pkg.sv
// Shared opcodes, FSM states and constants for the BRAM debug sequencer.
package bram_dbg_pkg;

    typedef enum logic [1:0] {
        OP_LOAD    = 2'd0,
        OP_RUN     = 2'd1,
        OP_DUMP    = 2'd2,
        OP_ILLEGAL = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_RUN_RST   = 3'd2,
        ST_RUN       = 3'd3,
        ST_DUMP_ADDR = 3'd4,
        ST_DUMP_WAIT = 3'd5,
        ST_DUMP_OUT  = 3'd6
    } state_e;

    localparam int unsigned WORD_BYTES = 4;
    localparam logic [3:0]  FULL_WE    = 4'b1111;

    // Byte address of a word index; callers truncate to the port width.
    function automatic logic [31:0] word_addr(input logic [31:0] idx);
        return 32'(idx * WORD_BYTES);
    endfunction

endpackage

// File: rtl/bram_dbg_chan_mux.sv
// Fans the single registered debug port out to the selected channel and
// selects that channel's read data back.
module bram_dbg_chan_mux #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CH_W   = 1
) (
    input  logic [CH_W-1:0]          ch_i,
    input  logic [ADDR_W-1:0]        a2_i,
    input  logic [DATA_W-1:0]        wd2_i,
    input  logic [3:0]               we2_i,
    output logic [NUM_CH*ADDR_W-1:0] ram_a2_o,
    output logic [NUM_CH*DATA_W-1:0] ram_wd2_o,
    output logic [NUM_CH*4-1:0]      ram_we2_o,
    input  logic [NUM_CH*DATA_W-1:0] ram_rd2_i,
    output logic [DATA_W-1:0]        rd2_o
);

    // Unselected channels see an all-zero port so they can never be written.
    always_comb begin
        ram_a2_o  = '0;
        ram_wd2_o = '0;
        ram_we2_o = '0;
        rd2_o     = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (32'(ch_i) == c) begin
                ram_a2_o[c*ADDR_W +: ADDR_W]  = a2_i;
                ram_wd2_o[c*DATA_W +: DATA_W] = wd2_i;
                ram_we2_o[c*4 +: 4]           = we2_i;
                rd2_o                         = ram_rd2_i[c*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/bram_debug_sequencer.sv
// Load/run/dump sequencer driving the debug port of NUM_CH block RAMs and the
// core reset, controlled through valid/ready command and stream interfaces.
module bram_debug_sequencer
    import bram_dbg_pkg::*;
#(
    parameter  int unsigned NUM_CH     = 2,
    parameter  int unsigned WORDS      = 4096,
    parameter  int unsigned DATA_W     = 32,
    parameter  int unsigned ADDR_W     = 32,
    parameter  int unsigned RST_CYCLES = 5,
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     CPU_CLK,
    input  logic                     CPU_RST,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [CH_W-1:0]          cmd_ch,
    input  logic [31:0]              cmd_arg,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [DATA_W-1:0]        ld_data,
    output logic                     dp_valid,
    input  logic                     dp_ready,
    output logic [DATA_W-1:0]        dp_data,
    output logic [ADDR_W-1:0]        dp_addr,
    output logic                     dp_last,
    output logic                     core_rst,
    output logic [NUM_CH*ADDR_W-1:0] ram_a2,
    output logic [NUM_CH*DATA_W-1:0] ram_wd2,
    output logic [NUM_CH*4-1:0]      ram_we2,
    input  logic [NUM_CH*DATA_W-1:0] ram_rd2,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    state_e              state_q;
    logic [CH_W-1:0]     ch_q;
    logic [31:0]         cnt_q;
    logic [31:0]         idx_q;
    logic [ADDR_W-1:0]   a2_q;
    logic [DATA_W-1:0]   wd2_q;
    logic [3:0]          we2_q;
    logic [DATA_W-1:0]   dp_data_q;
    logic [ADDR_W-1:0]   dp_addr_q;
    logic                dp_valid_q;
    logic                dp_last_q;
    logic                core_rst_q;
    logic                cmd_ready_q;
    logic                ld_ready_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;

    op_e                 cmd_op_c;
    logic                cmd_bad_c;
    logic                last_idx_c;
    logic [ADDR_W-1:0]   idx_addr_c;
    logic [DATA_W-1:0]   rd2_sel_c;

    assign cmd_op_c   = op_e'(cmd_op);
    assign last_idx_c = (idx_q == cnt_q - 32'd1);
    assign idx_addr_c = ADDR_W'(word_addr(idx_q));

    // Reject illegal opcodes, absent channels and out-of-range transfer sizes.
    assign cmd_bad_c = (cmd_op_c == OP_ILLEGAL) || (32'(cmd_ch) >= NUM_CH) ||
                       (((cmd_op_c == OP_LOAD) || (cmd_op_c == OP_DUMP)) &&
                        ((cmd_arg == 32'd0) || (cmd_arg > WORDS)));

    always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
        if (CPU_RST) begin
            state_q     <= ST_IDLE;
            ch_q        <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            a2_q        <= '0;
            wd2_q       <= '0;
            we2_q       <= '0;
            dp_data_q   <= '0;
            dp_addr_q   <= '0;
            dp_valid_q  <= 1'b0;
            dp_last_q   <= 1'b0;
            core_rst_q  <= 1'b1;
            cmd_ready_q <= 1'b1;
            ld_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            we2_q  <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        if (cmd_bad_c) begin
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                        end else begin
                            ch_q        <= cmd_ch;
                            cnt_q       <= cmd_arg;
                            idx_q       <= '0;
                            a2_q        <= '0;
                            wd2_q       <= '0;
                            cmd_ready_q <= 1'b0;
                            busy_q      <= 1'b1;
                            case (cmd_op_c)
                                OP_LOAD: begin
                                    state_q    <= ST_LOAD;
                                    ld_ready_q <= 1'b1;
                                end
                                OP_RUN:  state_q <= ST_RUN_RST;
                                default: state_q <= ST_DUMP_ADDR;
                            endcase
                        end
                    end
                end

                ST_LOAD: begin
                    if (ld_valid && ld_ready_q) begin
                        a2_q  <= idx_addr_c;
                        wd2_q <= ld_data;
                        we2_q <= FULL_WE;
                        idx_q <= idx_q + 32'd1;
                        if (last_idx_c) begin
                            state_q     <= ST_IDLE;
                            ld_ready_q  <= 1'b0;
                            cmd_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                        end
                    end
                end

                // idx_q doubles as the cycle counter for both run phases.
                ST_RUN_RST: begin
                    if (idx_q + 32'd1 >= RST_CYCLES) begin
                        idx_q <= '0;
                        if (cnt_q == 32'd0) begin
                            state_q     <= ST_IDLE;
                            cmd_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            state_q    <= ST_RUN;
                            core_rst_q <= 1'b0;
                        end
                    end else begin
                        idx_q <= idx_q + 32'd1;
                    end
                end

                ST_RUN: begin
                    if (last_idx_c) begin
                        state_q     <= ST_IDLE;
                        core_rst_q  <= 1'b1;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 32'd1;
                    end
                end

                ST_DUMP_ADDR: begin
                    a2_q    <= idx_addr_c;
                    state_q <= ST_DUMP_WAIT;
                end

                ST_DUMP_WAIT: state_q <= ST_DUMP_OUT;

                // First cycle here captures the read word; afterwards hold until accepted.
                ST_DUMP_OUT: begin
                    if (!dp_valid_q) begin
                        dp_valid_q <= 1'b1;
                        dp_data_q  <= rd2_sel_c;
                        dp_addr_q  <= idx_addr_c;
                        dp_last_q  <= last_idx_c;
                    end else if (dp_ready) begin
                        dp_valid_q <= 1'b0;
                        dp_last_q  <= 1'b0;
                        idx_q      <= idx_q + 32'd1;
                        if (last_idx_c) begin
                            state_q     <= ST_IDLE;
                            cmd_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            state_q <= ST_DUMP_ADDR;
                        end
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    bram_dbg_chan_mux #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .CH_W   (CH_W)
    ) u_chan_mux (
        .ch_i      (ch_q),
        .a2_i      (a2_q),
        .wd2_i     (wd2_q),
        .we2_i     (we2_q),
        .ram_a2_o  (ram_a2),
        .ram_wd2_o (ram_wd2),
        .ram_we2_o (ram_we2),
        .ram_rd2_i (ram_rd2),
        .rd2_o     (rd2_sel_c)
    );

    assign cmd_ready = cmd_ready_q;
    assign ld_ready  = ld_ready_q;
    assign dp_valid  = dp_valid_q;
    assign dp_data   = dp_data_q;
    assign dp_addr   = dp_addr_q;
    assign dp_last   = dp_last_q;
    assign core_rst  = core_rst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_bram_debug_sequencer.sv
// Bench for bram_debug_sequencer: behavioural BRAM fixture, shadow-memory
// model of expected contents, and cycle-count expectations per command.
module tb_bram_debug_sequencer;

    localparam int unsigned NCH   = 3;
    localparam int unsigned WORDS = 4096;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 32;
    localparam int unsigned RSTC  = 5;

    localparam logic [1:0] OP_LD  = 2'd0;
    localparam logic [1:0] OP_RN  = 2'd1;
    localparam logic [1:0] OP_DP  = 2'd2;
    localparam logic [1:0] OP_BAD = 2'd3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid, cmd_ready;
    logic [1:0]        cmd_op;
    logic [1:0]        cmd_ch;
    logic [31:0]       cmd_arg;
    logic              ld_valid, ld_ready;
    logic [DW-1:0]     ld_data;
    logic              dp_valid, dp_ready, dp_last;
    logic [DW-1:0]     dp_data;
    logic [AW-1:0]     dp_addr;
    logic              core_rst, busy, done, err;
    logic [NCH*AW-1:0] ram_a2;
    logic [NCH*DW-1:0] ram_wd2;
    logic [NCH*4-1:0]  ram_we2;
    logic [NCH*DW-1:0] ram_rd2;

    always #5 clk = ~clk;

    bram_debug_sequencer #(
        .NUM_CH     (NCH),
        .WORDS      (WORDS),
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .RST_CYCLES (RSTC)
    ) dut (
        .CPU_CLK   (clk),
        .CPU_RST   (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_ch    (cmd_ch),
        .cmd_arg   (cmd_arg),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_data   (ld_data),
        .dp_valid  (dp_valid),
        .dp_ready  (dp_ready),
        .dp_data   (dp_data),
        .dp_addr   (dp_addr),
        .dp_last   (dp_last),
        .core_rst  (core_rst),
        .ram_a2    (ram_a2),
        .ram_wd2   (ram_wd2),
        .ram_we2   (ram_we2),
        .ram_rd2   (ram_rd2),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // Behavioural BRAMs with 1-cycle synchronous read on the debug port.
    logic [DW-1:0] mem [NCH][WORDS];
    always @(posedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (ram_we2[c*4 +: 4] != 4'h0)
                mem[c][ram_a2[c*AW+2 +: 12]] <= ram_wd2[c*DW +: DW];
            ram_rd2[c*DW +: DW] <= mem[c][ram_a2[c*AW+2 +: 12]];
        end
    end

    typedef struct packed {
        logic [1:0]  c;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  we;
    } wr_t;

    wr_t wq[$];
    int  done_cnt = 0;
    int  err_cnt  = 0;

    always @(negedge clk) begin : mon
        wr_t w;
        if (done) done_cnt++;
        if (err)  err_cnt++;
        for (int c = 0; c < NCH; c++) begin
            if (ram_we2[c*4 +: 4] != 4'h0) begin
                w.c  = 2'(c);
                w.a  = ram_a2[c*AW +: AW];
                w.d  = ram_wd2[c*DW +: DW];
                w.we = ram_we2[c*4 +: 4];
                wq.push_back(w);
            end
        end
    end

    logic [31:0] shadow [NCH][WORDS];
    int          loaded [NCH];
    logic [31:0] ld_buf [WORDS];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_cmds = 0;
    int          n_badcmds = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after acceptance.
    task automatic issue(input logic [1:0] op, input logic [1:0] ch, input logic [31:0] arg);
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_ch    = ch;
        cmd_arg   = arg;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_arg   = $urandom;
        n_cmds++;
    endtask

    task automatic do_load(input logic [1:0] ch, input int n, input bit gaps);
        int  k, cyc;
        bit  v, hs;
        wr_t w;
        issue(OP_LD, ch, 32'(n));
        chk("load_ready", ld_ready, 1);
        chk("load_busy", busy, 1);
        k = 0;
        cyc = 0;
        while (k < n && cyc < n*8 + 50) begin
            v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            ld_valid = v;
            ld_data  = v ? ld_buf[k] : $urandom;
            hs = v && ld_ready;
            @(negedge clk);
            cyc++;
            if (hs) begin
                chk("load_done", done, (k == n-1));
                if (k == n-1) begin
                    chk("load_err", err, 0);
                    chk("load_ready_drop", ld_ready, 0);
                end
                k++;
            end
        end
        ld_valid = 1'b0;
        chk("load_beats", k, n);
        @(negedge clk);
        chk("load_wr_count", wq.size(), n);
        for (int i = 0; i < n && wq.size() > 0; i++) begin
            w = wq.pop_front();
            chk("load_wr_addr", {w.c, w.a}, {ch, 32'(i*4)});
            chk("load_wr_data", {w.we, w.d}, {4'hF, ld_buf[i]});
        end
        wq.delete();
        for (int i = 0; i < n; i++) shadow[ch][i] = ld_buf[i];
        if (n > loaded[ch]) loaded[ch] = n;
    endtask

    task automatic do_run(input int arg);
        int hi, lo, cyc;
        issue(OP_RN, 2'($urandom_range(0, NCH-1)), 32'(arg));
        hi = 0;
        lo = 0;
        cyc = 0;
        while (!done && cyc < int'(RSTC) + arg + 20) begin
            if (core_rst) begin
                if (lo != 0) break;
                hi++;
            end else begin
                lo++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("run_rst_cycles", hi, RSTC);
        chk("run_low_cycles", lo, arg);
        chk("run_done", done, 1);
        chk("run_core_rst_back", core_rst, 1);
        chk("run_err", err, 0);
        chk("run_busy", busy, 0);
    endtask

    // mode: 0 = always ready, 1 = ready every other cycle, 2 = random ready
    task automatic do_dump(input logic [1:0] ch, input int n, input int mode,
                           output logic [31:0] last_addr);
        int k, cyc, since;
        bit seen, rdy, tog, hs;
        issue(OP_DP, ch, 32'(n));
        k = 0; cyc = 0; since = 0; seen = 0; tog = 0;
        last_addr = '1;
        while (k < n && cyc < n*12 + 50) begin
            if (dp_valid) begin
                if (!seen) chk("dump_latency", since, 3);
                seen = 1;
                chk("dump_data", dp_data, shadow[ch][k]);
                chk("dump_addr", dp_addr, 32'(k*4));
                chk("dump_last", dp_last, (k == n-1));
            end
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
            tog = ~tog;
            dp_ready = rdy;
            hs = dp_valid && rdy;
            if (hs) last_addr = dp_addr;
            @(negedge clk);
            cyc++;
            if (hs) begin
                k++;
                since = 0;
                seen = 0;
            end else begin
                since++;
            end
        end
        dp_ready = 1'b0;
        chk("dump_beats", k, n);
        chk("dump_done", done, 1);
        chk("dump_err", err, 0);
        chk("dump_valid_drop", dp_valid, 0);
        chk("dump_busy", busy, 0);
    endtask

    task automatic do_bad(input logic [1:0] op, input logic [1:0] ch, input logic [31:0] arg);
        issue(op, ch, arg);
        n_badcmds++;
        chk("bad_done", done, 1);
        chk("bad_err", err, 1);
        chk("bad_busy", busy, 0);
        chk("bad_cmd_ready", cmd_ready, 1);
        chk("bad_core_rst", core_rst, 1);
        @(negedge clk);
        chk("bad_pulse_len", {done, err}, 2'b00);
        chk("bad_no_write", wq.size(), 0);
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] la;
        int          n, sel, cyc;
        logic [1:0]  ch;

        cmd_valid = 1'b0; cmd_op = '0; cmd_ch = '0; cmd_arg = '0;
        ld_valid = 1'b0; ld_data = '0; dp_ready = 1'b0;
        for (int c = 0; c < NCH; c++) loaded[c] = 0;

        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_ld_ready", ld_ready, 0);
        chk("rst_dp_valid", dp_valid, 0);
        chk("rst_dp_last", dp_last, 0);
        chk("rst_dp_data", dp_data, 0);
        chk("rst_dp_addr", dp_addr, 0);
        chk("rst_core_rst", core_rst, 1);
        chk("rst_flags", {busy, done, err}, 3'b000);
        chk("rst_ram_a2", |ram_a2, 0);
        chk("rst_ram_wd2", |ram_wd2, 0);
        chk("rst_ram_we2", ram_we2, 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed load of three instructions into ch1.
        ld_buf[0] = 32'h00000013;
        ld_buf[1] = 32'h00100093;
        ld_buf[2] = 32'h00208113;
        do_load(2'd1, 3, 1'b0);

        // Directed run with stray stream activity that must be ignored.
        ld_valid = 1'b1;
        ld_data  = 32'hDEADBEEF;
        dp_ready = 1'b1;
        do_run(10);
        do_run(0);
        ld_valid = 1'b0;
        dp_ready = 1'b0;
        @(negedge clk);
        chk("idle_ld_ignored", wq.size(), 0);

        // Directed load then stalled dump on ch0.
        ld_buf[0] = 32'h11; ld_buf[1] = 32'h22; ld_buf[2] = 32'h33; ld_buf[3] = 32'h44;
        do_load(2'd0, 4, 1'b0);
        do_dump(2'd0, 4, 1, la);
        chk("dump4_last_addr", la, 32'hC);

        // Rejected commands.
        do_bad(OP_BAD, 2'd0, 32'd1);
        do_bad(OP_LD, 2'd0, 32'd0);
        do_bad(OP_DP, 2'd0, 32'd4097);
        do_bad(OP_LD, 2'd1, 32'd4097);
        do_bad(OP_LD, 2'd3, 32'd2);

        // Randomized mix checked against the shadow memory.
        for (int it = 0; it < 10; it++) begin
            sel = $urandom_range(0, 2);
            ch  = 2'($urandom_range(0, NCH-1));
            if (sel == 0) begin
                n = $urandom_range(1, 24);
                for (int i = 0; i < n; i++) ld_buf[i] = $urandom;
                do_load(ch, n, 1'b1);
            end else if (sel == 1 && loaded[ch] > 0) begin
                n = $urandom_range(1, loaded[ch]);
                do_dump(ch, n, $urandom_range(0, 2), la);
            end else begin
                do_run($urandom_range(0, 15));
            end
        end

        // Full depth round trip on ch0.
        for (int i = 0; i < WORDS; i++) ld_buf[i] = $urandom;
        do_load(2'd0, WORDS, 1'b0);
        do_dump(2'd0, WORDS, 0, la);
        chk("full_last_addr", la, 32'h3FFC);

        // Asynchronous reset in the middle of a dump.
        issue(OP_DP, 2'd0, 32'd8);
        cyc = 0;
        while (!dp_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst_mid_dump_reached", dp_valid, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_dp_valid", dp_valid, 0);
        chk("rst_mid_core_rst", core_rst, 1);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_cmd_ready", cmd_ready, 1);
        chk("rst_mid_ld_ready", ld_ready, 0);
        chk("rst_mid_we2", ram_we2, 0);
        @(negedge clk);
        rst = 1'b0;
        n_cmds--;
        @(negedge clk);
        do_dump(2'd1, 3, 2, la);
        do_dump(2'd0, 5, 1, la);

        repeat (3) @(negedge clk);
        chk("done_pulse_total", done_cnt, n_cmds);
        chk("err_pulse_total", err_cnt, n_badcmds);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
